// File: rtl/exec_control.sv
// Execution control FSM: latches one instruction, drives ALU decode strobes for one cycle,
// updates carry/borrow flags, and performs an optional register writeback.
module exec_control (
    input  logic        clk_pi,
    input  logic        reset_pi,
    input  logic        instr_valid_pi,
    input  logic [15:0] instr_pi,
    output logic        instr_ready_po,
    output logic        arith_2op_po,
    output logic        arith_1op_po,
    output logic        addi_po,
    output logic        subi_po,
    output logic        load_or_store_po,
    output logic        stc_cmd_po,
    output logic        stb_cmd_po,
    output logic [2:0]  alu_func_po,
    output logic [5:0]  immediate_po,
    output logic [2:0]  reg1_addr_po,
    output logic [2:0]  reg2_addr_po,
    output logic [2:0]  wb_addr_po,
    input  logic [15:0] alu_result_pi,
    input  logic        carry_out_pi,
    input  logic        borrow_out_pi,
    input  logic [15:0] mem_rdata_pi,
    output logic        mem_we_po,
    output logic        wb_en_po,
    output logic [15:0] wb_data_po,
    output logic        carry_flag_po,
    output logic        borrow_flag_po,
    output logic        halted_po
);

    typedef enum logic [1:0] {FETCH, EXECUTE, WRITEBACK, HALTED} state_t;

    localparam logic [3:0]  OP_ARITH2  = 4'b0001;
    localparam logic [3:0]  OP_ARITH1  = 4'b0010;
    localparam logic [3:0]  OP_MOVI    = 4'b0011;
    localparam logic [3:0]  OP_ADDI    = 4'b0100;
    localparam logic [3:0]  OP_SUBI    = 4'b0101;
    localparam logic [3:0]  OP_LOAD    = 4'b0110;
    localparam logic [3:0]  OP_STOR    = 4'b0111;
    localparam logic [3:0]  OP_CONTROL = 4'b1111;
    localparam logic [11:0] CTRL_STC   = 12'h001;
    localparam logic [11:0] CTRL_STB   = 12'h002;
    localparam logic [11:0] CTRL_RESET = 12'hAAA;
    localparam logic [11:0] CTRL_HALT  = 12'hFFF;

    state_t      state, state_next;
    logic [15:0] instr_q;
    logic [3:0]  op;
    logic [11:0] ctrl;
    logic        is_control, writes_back, flag_load, soft_reset, halt_cmd;

    assign op         = instr_q[15:12];
    assign ctrl       = instr_q[11:0];
    assign is_control = (op == OP_CONTROL);
    assign soft_reset = is_control && (ctrl == CTRL_RESET);
    assign halt_cmd   = is_control && (ctrl == CTRL_HALT);
    assign writes_back = (op >= OP_ARITH2) && (op <= OP_LOAD);
    // Branches, NOP, HALT and unknown codes leave the flags untouched.
    assign flag_load  = ((op >= OP_ARITH2) && (op <= OP_STOR)) ||
                        (is_control && ((ctrl == CTRL_STC) || (ctrl == CTRL_STB)));

    // Operand fields always come from the latch, never from the live instruction bus.
    assign alu_func_po  = instr_q[2:0];
    assign immediate_po = instr_q[5:0];
    assign reg1_addr_po = instr_q[8:6];
    assign reg2_addr_po = instr_q[5:3];
    assign wb_addr_po   = instr_q[11:9];

    // NOTE: every output of this block gets a default before the case so no latch is inferred.
    always_comb begin
        state_next       = state;
        instr_ready_po   = 1'b0;
        arith_2op_po     = 1'b0;
        arith_1op_po     = 1'b0;
        addi_po          = 1'b0;
        subi_po          = 1'b0;
        load_or_store_po = 1'b0;
        stc_cmd_po       = 1'b0;
        stb_cmd_po       = 1'b0;
        mem_we_po        = 1'b0;
        wb_en_po         = 1'b0;
        halted_po        = 1'b0;
        case (state)
            FETCH: begin
                instr_ready_po = 1'b1;
                if (instr_valid_pi) state_next = EXECUTE;
            end
            EXECUTE: begin
                arith_2op_po     = (op == OP_ARITH2);
                arith_1op_po     = (op == OP_ARITH1);
                addi_po          = (op == OP_ADDI);
                subi_po          = (op == OP_SUBI);
                load_or_store_po = (op == OP_LOAD) || (op == OP_STOR);
                stc_cmd_po       = is_control && (ctrl == CTRL_STC);
                stb_cmd_po       = is_control && (ctrl == CTRL_STB);
                mem_we_po        = (op == OP_STOR);
                if (writes_back)   state_next = WRITEBACK;
                else if (halt_cmd) state_next = HALTED;
                else               state_next = FETCH;
            end
            WRITEBACK: begin
                wb_en_po   = 1'b1;
                state_next = FETCH;
            end
            HALTED: begin
                halted_po = 1'b1;
            end
            default: state_next = FETCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_pi or posedge reset_pi) begin
        if (reset_pi) begin
            state          <= FETCH;
            instr_q        <= '0;
            carry_flag_po  <= 1'b0;
            borrow_flag_po <= 1'b0;
            wb_data_po     <= '0;
        end else begin
            state <= state_next;
            if (state == FETCH && instr_valid_pi) instr_q <= instr_pi;
            if (state == EXECUTE) begin
                if (soft_reset) begin
                    carry_flag_po  <= 1'b0;
                    borrow_flag_po <= 1'b0;
                end else if (flag_load) begin
                    carry_flag_po  <= carry_out_pi;
                    borrow_flag_po <= borrow_out_pi;
                end
                if (op == OP_LOAD)      wb_data_po <= mem_rdata_pi;
                else if (op == OP_MOVI) wb_data_po <= {10'b0, instr_q[5:0]};
                else                    wb_data_po <= alu_result_pi;
            end
        end
    end

endmodule

// File: tb/tb_exec_control.sv
// Randomized self-checking bench for exec_control against an instruction-level reference model.
module tb_exec_control;

    logic        clk_pi = 1'b0;
    logic        reset_pi;
    logic        instr_valid_pi;
    logic [15:0] instr_pi;
    logic        instr_ready_po;
    logic        arith_2op_po, arith_1op_po, addi_po, subi_po, load_or_store_po, stc_cmd_po, stb_cmd_po;
    logic [2:0]  alu_func_po;
    logic [5:0]  immediate_po;
    logic [2:0]  reg1_addr_po, reg2_addr_po, wb_addr_po;
    logic [15:0] alu_result_pi;
    logic        carry_out_pi, borrow_out_pi;
    logic [15:0] mem_rdata_pi;
    logic        mem_we_po, wb_en_po;
    logic [15:0] wb_data_po;
    logic        carry_flag_po, borrow_flag_po, halted_po;

    int n_checks = 0;
    int n_fail   = 0;
    bit m_carry, m_borrow;

    exec_control dut (
        .clk_pi(clk_pi), .reset_pi(reset_pi), .instr_valid_pi(instr_valid_pi), .instr_pi(instr_pi),
        .instr_ready_po(instr_ready_po), .arith_2op_po(arith_2op_po), .arith_1op_po(arith_1op_po),
        .addi_po(addi_po), .subi_po(subi_po), .load_or_store_po(load_or_store_po),
        .stc_cmd_po(stc_cmd_po), .stb_cmd_po(stb_cmd_po), .alu_func_po(alu_func_po),
        .immediate_po(immediate_po), .reg1_addr_po(reg1_addr_po), .reg2_addr_po(reg2_addr_po),
        .wb_addr_po(wb_addr_po), .alu_result_pi(alu_result_pi), .carry_out_pi(carry_out_pi),
        .borrow_out_pi(borrow_out_pi), .mem_rdata_pi(mem_rdata_pi), .mem_we_po(mem_we_po),
        .wb_en_po(wb_en_po), .wb_data_po(wb_data_po), .carry_flag_po(carry_flag_po),
        .borrow_flag_po(borrow_flag_po), .halted_po(halted_po)
    );

    always #5 clk_pi = ~clk_pi;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] strobes_now();
        return {arith_2op_po, arith_1op_po, addi_po, subi_po, load_or_store_po, stc_cmd_po, stb_cmd_po};
    endfunction

    // Expected strobes straight from the opcode table: {2op,1op,addi,subi,ld/st,stc,stb}.
    function automatic logic [6:0] exp_strobes(input logic [15:0] ins);
        case (ins[15:12])
            4'h1: return 7'b1000000;
            4'h2: return 7'b0100000;
            4'h4: return 7'b0010000;
            4'h5: return 7'b0001000;
            4'h6, 4'h7: return 7'b0000100;
            4'hF: return (ins[11:0] == 12'h001) ? 7'b0000010 :
                         (ins[11:0] == 12'h002) ? 7'b0000001 : 7'b0000000;
            default: return 7'b0000000;
        endcase
    endfunction

    // Called at a falling edge with the DUT in FETCH; leaves it at a falling edge after the instruction.
    task automatic run_instr(input logic [15:0] ins, input logic [15:0] alu, input bit c, input bit b,
                             input logic [15:0] mem);
        logic [3:0]  op;
        logic [11:0] ctrl;
        bit          wb, halt;
        logic [15:0] exp_data;
        op   = ins[15:12];
        ctrl = ins[11:0];
        wb   = (op >= 4'h1) && (op <= 4'h6);
        halt = (op == 4'hF) && (ctrl == 12'hFFF);
        exp_data = (op == 4'h6) ? mem : (op == 4'h3) ? {10'b0, ins[5:0]} : alu;

        check("ready_in_fetch", instr_ready_po, 1);
        instr_valid_pi = 1'b1;
        instr_pi       = ins;
        @(negedge clk_pi);
        // Garbage on the bus during EXECUTE must not reach the latch.
        instr_valid_pi = 1'($urandom);
        instr_pi       = 16'($urandom);
        alu_result_pi  = alu;
        carry_out_pi   = c;
        borrow_out_pi  = b;
        mem_rdata_pi   = mem;
        check("exec_strobes", strobes_now(), exp_strobes(ins));
        check("exec_func", alu_func_po, ins[2:0]);
        check("exec_imm", immediate_po, ins[5:0]);
        check("exec_reg1", reg1_addr_po, ins[8:6]);
        check("exec_reg2", reg2_addr_po, ins[5:3]);
        check("exec_mem_we", mem_we_po, op == 4'h7);
        check("exec_ready", instr_ready_po, 0);
        check("exec_wb_en", wb_en_po, 0);

        if ((op == 4'hF) && (ctrl == 12'hAAA)) begin
            m_carry = 0; m_borrow = 0;
        end else if (((op >= 4'h1) && (op <= 4'h7)) || ((op == 4'hF) && (ctrl == 12'h001 || ctrl == 12'h002))) begin
            m_carry = c; m_borrow = b;
        end

        @(negedge clk_pi);
        instr_pi = 16'($urandom);
        check("carry_flag", carry_flag_po, m_carry);
        check("borrow_flag", borrow_flag_po, m_borrow);
        check("post_exec_mem_we", mem_we_po, 0);
        if (wb) begin
            check("wb_en", wb_en_po, 1);
            check("wb_addr", wb_addr_po, ins[11:9]);
            check("wb_data", wb_data_po, exp_data);
            check("wb_ready", instr_ready_po, 0);
            check("wb_strobes", strobes_now(), 0);
            @(negedge clk_pi);
        end else begin
            check("no_wb_en", wb_en_po, 0);
        end
        check("halted", halted_po, halt);
        check("ready_after", instr_ready_po, !halt);
        instr_valid_pi = 1'b0;
    endtask

    task automatic rand_instr(output logic [15:0] ins);
        logic [11:0] ctrl;
        ins = 16'($urandom);
        if (ins[15:12] == 4'hF) begin
            case ($urandom_range(0, 3))
                0: ctrl = 12'h001;
                1: ctrl = 12'h002;
                2: ctrl = 12'hAAA;
                default: ctrl = 12'($urandom);
            endcase
            if (ctrl == 12'hFFF) ctrl = 12'h003;
            ins[11:0] = ctrl;
        end
    endtask

    task automatic pulse_reset();
        #1 reset_pi = 1'b1;
        #1;
        m_carry = 0; m_borrow = 0;
        check("rst_ready", instr_ready_po, 1);
        check("rst_halted", halted_po, 0);
        check("rst_wb_en", wb_en_po, 0);
        check("rst_mem_we", mem_we_po, 0);
        check("rst_strobes", strobes_now(), 0);
        check("rst_flags", {carry_flag_po, borrow_flag_po}, 0);
        check("rst_wb_data", wb_data_po, 0);
        check("rst_instr_fields", {wb_addr_po, reg1_addr_po, reg2_addr_po, alu_func_po}, 0);
        @(negedge clk_pi);
        reset_pi = 1'b0;
    endtask

    initial begin
        logic [15:0] ins;
        reset_pi = 1'b1;
        instr_valid_pi = 1'b0;
        instr_pi = '0;
        alu_result_pi = '0;
        carry_out_pi = 1'b0;
        borrow_out_pi = 1'b0;
        mem_rdata_pi = '0;
        @(negedge clk_pi);
        pulse_reset();
        check("ready_first_cycle", instr_ready_po, 1);

        // Directed: ADD, MOVI, STOR, STC then soft RESET.
        run_instr(16'h1000, 16'h1234, 1'b1, 1'b0, 16'h0);
        run_instr(16'h362A, 16'hBEEF, 1'b0, 1'b1, 16'h5555);
        run_instr(16'h7123, 16'h4321, 1'b1, 1'b1, 16'h9999);
        run_instr(16'hF001, 16'h0000, 1'b1, 1'b0, 16'h0);
        check("stc_carry", carry_flag_po, 1);
        run_instr(16'hFAAA, 16'h0000, 1'b1, 1'b1, 16'h0);
        check("softreset_carry", carry_flag_po, 0);

        // Randomized instruction stream against the model.
        for (int i = 0; i < 300; i++) begin
            rand_instr(ins);
            run_instr(ins, 16'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
        end

        // HALT holds off new instructions until reset.
        run_instr(16'hFFFF, 16'h0, 1'b1, 1'b1, 16'h0);
        instr_valid_pi = 1'b1;
        for (int i = 0; i < 20; i++) begin
            instr_pi = 16'($urandom);
            @(negedge clk_pi);
            check("halt_hold", {halted_po, instr_ready_po}, 2'b10);
        end
        instr_valid_pi = 1'b0;
        pulse_reset();
        check("after_halt_reset", {halted_po, instr_ready_po}, 2'b01);

        // Reset in mid-WRITEBACK aborts the write and clears the flags.
        instr_valid_pi = 1'b1;
        instr_pi = 16'h1E40;
        @(negedge clk_pi);
        instr_valid_pi = 1'b0;
        carry_out_pi = 1'b1;
        borrow_out_pi = 1'b1;
        alu_result_pi = 16'hCAFE;
        @(negedge clk_pi);
        check("pre_reset_wb_en", wb_en_po, 1);
        pulse_reset();
        check("post_reset_fetch", instr_ready_po, 1);
        run_instr(16'h2A88, 16'h0F0F, 1'b0, 1'b1, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
